// File: rtl/red_pitaya_decimator_block.sv
// Purpose : block-averaging decimator; sums 2^d consecutive samples and emits their floor mean.
// Latency : mean of a block appears one cycle after its last sample, with a one-cycle valid_o strobe.
// Backpr. : none; one sample is consumed every enabled cycle and the consumer must take every strobe.
//
// Ports:
//   clk_i    - system clock, rising edge
//   rst_i    - asynchronous active-high reset, clears all state
//   enable_i - 1 = run, 0 = discard the current partial block and hold dat_o
//   set_dec  - requested log2 decimation d, clamped to LOG2MAXDEC
//   dat_i    - signed input sample, one per cycle
//   dat_o    - signed registered block mean (arithmetic shift, rounds toward -inf)
//   valid_o  - one-cycle strobe marking a new dat_o (constantly high when d = 0)

module red_pitaya_decimator_block #(
   parameter int SIGNALBITS = 14,
   parameter int LOG2MAXDEC = 10,
   parameter int DECBITS    = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         enable_i,
   input  logic [DECBITS-1:0]           set_dec,
   input  logic signed [SIGNALBITS-1:0] dat_i,
   output logic signed [SIGNALBITS-1:0] dat_o,
   output logic                         valid_o
);

   // Accumulator holds 2^LOG2MAXDEC full-scale samples without wrapping.
   localparam int AW = SIGNALBITS + LOG2MAXDEC;
   localparam int CW = LOG2MAXDEC + 1;
   localparam int QW = $clog2(LOG2MAXDEC + 1);

   logic signed [AW-1:0]         acc;
   logic [CW-1:0]                cnt;
   logic [QW-1:0]                dec_q;

   logic [QW-1:0]                d_eff;
   logic signed [AW-1:0]         sum;
   logic signed [SIGNALBITS-1:0] mean;
   logic                         blk_last;

   // Clamp the requested setting; settings that clamp to the same value
   // compare equal against dec_q and therefore do not restart a block.
   always_comb begin
      d_eff = QW'(set_dec);
      if (32'(set_dec) > LOG2MAXDEC) begin
         d_eff = QW'(LOG2MAXDEC);
      end
   end

   always_comb begin
      sum      = acc + AW'(dat_i);
      // Arithmetic shift of the signed sum: floor division by 2^dec_q.
      mean     = SIGNALBITS'(sum >>> dec_q);
      blk_last = (cnt == ((CW'(1) << dec_q) - CW'(1)));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc     <= '0;
         cnt     <= '0;
         dec_q   <= '0;
         dat_o   <= '0;
         valid_o <= 1'b0;
      end else if (!enable_i) begin
         // Partial block is thrown away; dat_o keeps the last mean and the
         // setting is still tracked so re-enable does not look like a change.
         acc     <= '0;
         cnt     <= '0;
         valid_o <= 1'b0;
         dec_q   <= d_eff;
      end else if (d_eff != dec_q) begin
         // New setting: restart block alignment, this cycle's sample is dropped.
         dec_q   <= d_eff;
         acc     <= '0;
         cnt     <= '0;
         valid_o <= 1'b0;
      end else if (blk_last) begin
         // Last sample of the block: publish and start the next block with
         // no gap cycle.
         dat_o   <= mean;
         valid_o <= 1'b1;
         acc     <= '0;
         cnt     <= '0;
      end else begin
         acc     <= sum;
         cnt     <= cnt + CW'(1);
         valid_o <= 1'b0;
      end
   end

endmodule

// File: doc/red_pitaya_decimator_block.md
# red_pitaya_decimator_block

Block-averaging decimator placed directly downstream of the cascaded low/high-pass filter block. It sums 2^d consecutive filtered samples and outputs their arithmetic mean, one result per block, with a single-cycle valid strobe. Scope, lock-in and other slow consumers use it to obtain a reduced-rate, alias-suppressed stream. d is set at run time.

## Interface
- SIGNALBITS, 14, width of the signed input and output samples (matches the filter block output width).
- LOG2MAXDEC, 10, maximum log2 decimation factor; the largest block is 2^LOG2MAXDEC samples.
- DECBITS, 4, width of the decimation setting port.

- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  1 = run; 0 = discard the current block and hold.
- set_dec  in  DECBITS  requested log2 decimation d (unsigned).
- dat_i  in  SIGNALBITS  signed sample from the filter block; one new sample every cycle.
- dat_o  out  SIGNALBITS  signed block mean, registered.
- valid_o  out  1  one-cycle strobe marking a new dat_o.

## Operation
- Effective setting: d_eff = min(set_dec, LOG2MAXDEC). N = 2^d_eff.
- State:
  - acc: signed, SIGNALBITS+LOG2MAXDEC bits. It cannot overflow, because N full-scale samples fit in this width.
  - cnt: LOG2MAXDEC+1 bits.
  - dec_q: registered d_eff.
  - dat_o, valid_o.
- Reset (rst_i high, asynchronous): acc=0, cnt=0, dec_q=0, dat_o=0, valid_o=0. All are held while rst_i is high.
- Priority each cycle, highest first: reset, disable, setting change, accumulate.
- Disable (enable_i=0):
  - acc=0, cnt=0, valid_o=0.
  - dat_o holds its last value.
  - dec_q still tracks d_eff.
- Setting change (enable_i=1 and d_eff != dec_q):
  - dec_q <= d_eff, acc <= 0, cnt <= 0, valid_o <= 0.
  - The dat_i of this cycle is discarded.
- Accumulate (enable_i=1, d_eff == dec_q):
  - sum = acc + dat_i (sign-extended).
  - If cnt == N-1:
    - dat_o <= sum >>> dec_q. This is an arithmetic shift, i.e. rounding toward minus infinity.
    - valid_o <= 1; acc <= 0; cnt <= 0.
  - Otherwise: acc <= sum, cnt <= cnt+1, valid_o <= 0.
- d_eff = 0: every accepted sample completes a block, so dat_o = dat_i delayed by one cycle and valid_o stays high continuously.
- Blocks are contiguous. There is no gap cycle between the last sample of one block and the first sample of the next.

## Timing
- Latency: the last sample of a block is presented in cycle t. dat_o and valid_o reflect that block from cycle t+1. valid_o is high for exactly one cycle, except when d_eff=0.
- Steady state: valid_o asserts once every N cycles. dat_o is stable between strobes.
- After a setting change detected in cycle c: samples c+1 … c+N form the first block, and valid_o asserts in cycle c+N+1.
- After rst_i is released or enable_i rises in cycle r (with no setting change pending): samples r … r+N-1 form the first block, and valid_o asserts in cycle r+N.
- First cycle after reset with set_dec != 0: this counts as a setting change, because dec_q=0. That cycle's sample is discarded.
- Reset asserted mid-block: the partial sum is lost and no valid_o is emitted for it. Outputs go to 0 without waiting for a clock edge.
- enable_i and a setting change in the same cycle: disable wins, and dec_q still updates.
- set_dec > LOG2MAXDEC: clamps to LOG2MAXDEC. Moving between two values that clamp to the same d_eff is not a change.

## Test plan
- Constant input: set_dec=2, dat_i=100 held → valid_o every 4 cycles, dat_o=100 each time, and valid_o is never asserted on two consecutive cycles.
- Rounding:
  - set_dec=2, block 1,2,3,-7 (sum -1) → dat_o=-1.
  - Block -1,0,0,0 → dat_o=-1.
  - Block 1,0,0,0 → dat_o=0.
- Full scale: set_dec=10 for 1024 cycles.
  - dat_i=-8192 → dat_o=-8192.
  - dat_i=+8191 → dat_o=+8191.
  - No wrap in either case.
- Reconfiguration: set_dec=3, then after 5 samples set_dec=1 in cycle c.
  - No valid_o is emitted for the partial block.
  - valid_o rises in cycle c+3 with the mean of samples c+1 and c+2.
  - Then set_dec=15 → behaves as d=10 (valid_o every 1024 cycles).
- Disable and reset mid-block, with set_dec=4:
  - Drop enable_i after 7 samples → no valid_o, and dat_o keeps its previous value.
  - Re-enable → the next valid_o comes 16 cycles after enable.
  - Pulse rst_i between clock edges → dat_o=0 and valid_o=0 immediately.
- Pass-through: set_dec=0, random dat_i → dat_o(t+1)=dat_i(t) and valid_o constantly 1.
